// File: rtl/pulse_period_meter.sv
// pulse_period_meter
//
// Measures the interval between rising edges of pulse_in in clki cycles and
// reports each interval with a one-cycle strobe. A watchdog drops lock and
// raises 'timeout' when no edge arrives within TIMEOUT cycles of the last one.
//
// Parameters
//   WIDTH    width of the period counter and of 'period'
//   TIMEOUT  largest measurable period in cycles (2 .. 2^WIDTH-1)
//
// Ports
//   clki      in   system clock
//   resetn    in   asynchronous active-low reset (released synchronously upstream)
//   pulse_in  in   measured signal, may be asynchronous to clki
//   period    out  last measured interval, held until the next measurement
//   valid     out  one-cycle strobe, high in the cycle 'period' updates
//   timeout   out  level, set when no edge arrived within TIMEOUT cycles
//   locked    out  level, high while measuring
module pulse_period_meter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 24000000
) (
  input  logic             clki,
  input  logic             resetn,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  output logic             timeout,
  output logic             locked
);

  // Reject parameter combinations the counter cannot represent.
  if ((WIDTH < 32'd1) || (WIDTH > 32'd63)) begin : g_bad_width
    $error("pulse_period_meter: WIDTH must be in 1..63");
  end
  if ((TIMEOUT < 32'd2) ||
      (64'(TIMEOUT) > ((64'd1 << WIDTH) - 64'd1))) begin : g_bad_timeout
    $error("pulse_period_meter: TIMEOUT must be in 2..2^WIDTH-1");
  end

  // Count value at which the watchdog fires: TIMEOUT cycles after the edge
  // that cleared the counter.
  localparam logic [WIDTH-1:0] TERM_CNT = WIDTH'(TIMEOUT - 32'd1);
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             locked_q, locked_d;
  logic             edge_det_s;

  // Next-state logic: synchronizer shift, edge detect, FSM and counter.
  always_comb begin
    s1_d       = pulse_in;
    s2_d       = s1_q;
    s3_d       = s2_q;
    // s3 is the history flop; a high s2 with a low s3 is one clean rise.
    edge_det_s = s2_q & ~s3_q;

    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    timeout_d  = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (edge_det_s) begin
          // First edge only provides the reference point; nothing to report.
          cnt_d     = CNT_ZERO;
          timeout_d = 1'b0;
          state_d   = ST_MEASURE;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        if (edge_det_s) begin
          // cnt holds N-1 when the edge N cycles after the previous one is
          // consumed. The edge also wins against a simultaneous timeout.
          period_d = cnt_q + CNT_ONE;
          valid_d  = 1'b1;
          cnt_d    = CNT_ZERO;
        end else if (cnt_q == TERM_CNT) begin
          timeout_d = 1'b1;
          cnt_d     = CNT_ZERO;
          state_d   = ST_IDLE;
        end else begin
          cnt_d     = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = ST_IDLE;
      end
    endcase

    // Registered alongside the state so it tracks it in the same cycle.
    locked_d = (state_d == ST_MEASURE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clki or negedge resetn) begin
    if (!resetn) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      period_q  <= CNT_ZERO;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      locked_q  <= locked_d;
    end
  end

  assign period  = period_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign locked  = locked_q;

endmodule
